bus_split_seq: RTL
==================

// Module: bus_split_seq
// PURPOSE
//  Registered, parametrised successor to the TinyCPU bus splitter. Accepts an IN_W-bit word via
//  valid/ready handshake, presents a registered high/low split (G/T) and streams the word
//  out as NUM_FIELDS fields of FIELD_W bits, one field per accepted output beat.
//  Sits between the instruction/data bus and narrower consumers (ALU operand, nibble I/O).
// PARAMETERS
//  FIELD_W     4   width of one serial field, bits
//  NUM_FIELDS  3   fields per word; IN_W = FIELD_W*NUM_FIELDS (default 12)
//  HI_W        8   width of G (upper slice); T width LO_W = IN_W-HI_W; 1 <= HI_W < IN_W
//  MSB_FIRST   0   0: field 0 = K[FIELD_W-1:0] first; 1: most significant field first
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             K holds a word to accept
//  in_ready   out  1             block can accept K this cycle
//  K          in   IN_W          input word
//  G          out  HI_W          registered K[IN_W-1:LO_W] of last accepted word
//  T          out  LO_W          registered K[LO_W-1:0] of last accepted word
//  out_valid  out  1             F holds a valid field
//  out_ready  in   1             consumer takes F this cycle
//  F          out  FIELD_W       current field
//  f_idx      out  clog2(NF)     index of current field in emit order (0..NUM_FIELDS-1)
//  f_last     out  1             current field is the last of the word
// BEHAVIOUR
//  - Reset (async, rst_n=0): G=0, T=0, hold reg=0, out_valid=0, F=0, f_idx=0, f_last=0,
//    state=IDLE. Reset mid-word discards the word; no partial emission after release.
//  - States: IDLE (no word held), SHIFT (word held, out_valid=1).
//  - in_ready = (state==IDLE) | (state==SHIFT & f_last & out_ready); combinational from out_ready.
//  - Accept = in_valid & in_ready. On accept: hold<=K, G/T<=split of K, f_idx<=0, state<=SHIFT;
//    G/T update on the edge after accept (1-cycle latency) and hold until next accept.
//  - Beat = out_valid & out_ready. Non-last beat: f_idx<=f_idx+1. Last beat without accept:
//    state<=IDLE, out_valid<=0. Last beat with simultaneous accept: back-to-back, new word's
//    field 0 valid next cycle, no bubble (throughput 1 field/cycle).
//  - F, f_last are combinational selects of hold/f_idx; stable while out_valid & !out_ready.
//  - f_last = (f_idx==NUM_FIELDS-1). NUM_FIELDS=1: every beat is last.
//  - in_valid in SHIFT with !(f_last&out_ready): not accepted, K ignored, no state change.
//  - out_ready while IDLE: no effect. f_idx never exceeds NUM_FIELDS-1 (no wrap past last).
// CONFIGURATION
//  SPLIT_PARITY_EN defined: extra output F_par (1 bit) = ^F, valid with out_valid, and output
//    G_par (1 bit) = ^G registered with G; both reset to 0.
//  Not defined: ports F_par/G_par absent; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 with in_valid=1 -> G=0,T=0,out_valid=0,in_ready=1 after release.
//  2 K=12'h005 accepted, out_ready=1 -> G=8'h00,T=4'h5; F=5,0,0 on 3 cycles, f_last on 3rd.
//  3 K=12'hFE7, MSB_FIRST=0, out_ready toggled 1/0 -> F sequence 7,E,F; F/f_idx held on stalls;
//    G=8'hFE,T=4'h7.
//  4 Back-to-back K=12'hFFF then 12'hFCB, in_valid=1, out_ready=1 -> F=F,F,F,B,C,F with no
//    bubble; in_ready=1 only on cycle of each last beat.
//  5 rst_n pulsed low during field 1 of 12'hFE7 -> out_valid=0 immediately; no further fields.
//  6 SPLIT_PARITY_EN, K=12'hFE7 -> F_par=1,1,0 for F=7,E,F; G_par=1 (^8'hFE).

Source files
------------

// File: rtl/bus_split_seq_if.sv
// Handshake bundle for bus_split_seq: word input side, G/T split and serial field output side.
// When SPLIT_PARITY_EN is defined the bundle also carries F_par and G_par.
interface bus_split_seq_if #(
  parameter int FIELD_W    = 4,
  parameter int NUM_FIELDS = 3,
  parameter int HI_W       = 8
);
  localparam int IN_W  = FIELD_W * NUM_FIELDS;
  localparam int LO_W  = IN_W - HI_W;
  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   K;
  logic [HI_W-1:0]   G;
  logic [LO_W-1:0]   T;
  logic              out_valid;
  logic              out_ready;
  logic [FIELD_W-1:0] F;
  logic [IDX_W-1:0]  f_idx;
  logic              f_last;
`ifdef SPLIT_PARITY_EN
  logic              F_par;
  logic              G_par;
`endif

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // the producer holds valid and data stable until that edge.
  modport slave (
    input  in_valid, K, out_ready,
    output in_ready, G, T, out_valid, F, f_idx, f_last
`ifdef SPLIT_PARITY_EN
    , output F_par, G_par
`endif
  );

  modport master (
    output in_valid, K, out_ready,
    input  in_ready, G, T, out_valid, F, f_idx, f_last
`ifdef SPLIT_PARITY_EN
    , input F_par, G_par
`endif
  );
endinterface

// File: rtl/bus_split_seq.sv
// Registered bus splitter: latches a word, presents its G/T split and streams it out field by field.
// Optional SPLIT_PARITY_EN macro adds F_par (^F) and registered G_par (^G).
module bus_split_seq #(
  parameter int FIELD_W    = 4,
  parameter int NUM_FIELDS = 3,
  parameter int HI_W       = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_split_seq_if.slave  bus,
  output logic            state_dbg
);
  localparam int IN_W  = FIELD_W * NUM_FIELDS;
  localparam int LO_W  = IN_W - HI_W;
  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IN_W-1:0]    hold_q;
  logic [HI_W-1:0]    g_q;
  logic [LO_W-1:0]    t_q;
  logic               out_valid_c;
  logic               last_c;
  logic               in_ready_c;
  logic               accept;
  logic               beat;
  logic [IDX_W-1:0]   fld;
  logic [FIELD_W-1:0] field_c;

  always_comb begin
    out_valid_c = (state_q == SHIFT);
    last_c      = out_valid_c && (idx_q == LAST_IDX);
    in_ready_c  = (state_q == IDLE) || (last_c && bus.out_ready);
    accept      = bus.in_valid && in_ready_c;
    beat        = out_valid_c && bus.out_ready;
    state_d     = state_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (last_c) begin
            // A new word accepted on the last beat keeps streaming with no bubble.
            idx_d   = '0;
            state_d = accept ? SHIFT : IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Emit position to physical field number; MSB_FIRST walks from the top field down.
  always_comb begin
    fld     = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    field_c = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (fld == IDX_W'(i)) field_c = hold_q[i*FIELD_W +: FIELD_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      g_q    <= '0;
      t_q    <= '0;
    end else if (accept) begin
      hold_q <= bus.K;
      g_q    <= bus.K[IN_W-1:LO_W];
      t_q    <= bus.K[LO_W-1:0];
    end
  end

`ifdef SPLIT_PARITY_EN
  logic g_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      g_par_q <= 1'b0;
    else if (accept) g_par_q <= ^bus.K[IN_W-1:LO_W];
  end

  assign bus.F_par = ^field_c;
  assign bus.G_par = g_par_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.F         = field_c;
  assign bus.f_idx     = idx_q;
  assign bus.f_last    = last_c;
  assign bus.G         = g_q;
  assign bus.T         = t_q;
  assign state_dbg     = (state_q == SHIFT);
endmodule
